// File: rtl/sa3x3_act_feeder.sv
// Control and activation feed stage for a 3x3 weight-stationary systolic array.
// Latches weights per job, pulses load/clear, then streams skewed activation lanes.
module sa3x3_act_feeder #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned DRAIN_CYCLES = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            len,
    input  logic [9*DATA_W-1:0]   w_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3*DATA_W-1:0]   in_data,
    output logic [9*DATA_W-1:0]   w_out,
    output logic                  weight_load,
    output logic                  clear,
    output logic [DATA_W-1:0]     act_in1,
    output logic [DATA_W-1:0]     act_in2,
    output logic [DATA_W-1:0]     act_in3,
    output logic [2:0]            lane_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t              state;
    logic [7:0]          len_r;
    logic [7:0]          acc_cnt;
    logic [DCNT_W-1:0]   drain_cnt;

    // Skew-line stages ahead of the lane 2 / lane 3 output registers
    logic [DATA_W-1:0]   a2_d;
    logic                a2_v;
    logic [DATA_W-1:0]   a3_d0;
    logic                a3_v0;
    logic [DATA_W-1:0]   a3_d1;
    logic                a3_v1;

    logic                hs;

    // Ready depends only on state and count so upstream may gate valid on it
    assign in_ready = (state == STREAM) && (acc_cnt < len_r);
    assign hs       = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            len_r       <= '0;
            acc_cnt     <= '0;
            drain_cnt   <= '0;
            w_out       <= '0;
            weight_load <= 1'b0;
            clear       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            act_in1     <= '0;
            act_in2     <= '0;
            act_in3     <= '0;
            lane_valid  <= '0;
            a2_d        <= '0;
            a2_v        <= 1'b0;
            a3_d0       <= '0;
            a3_v0       <= 1'b0;
            a3_d1       <= '0;
            a3_v1       <= 1'b0;
        end else begin
            weight_load <= 1'b0;
            clear       <= 1'b0;
            done        <= 1'b0;

            // Skew line: non-handshake cycles shift in zero/invalid
            act_in1       <= hs ? in_data[DATA_W-1:0] : '0;
            lane_valid[0] <= hs;
            a2_d          <= hs ? in_data[2*DATA_W-1:DATA_W] : '0;
            a2_v          <= hs;
            act_in2       <= a2_d;
            lane_valid[1] <= a2_v;
            a3_d0         <= hs ? in_data[3*DATA_W-1:2*DATA_W] : '0;
            a3_v0         <= hs;
            a3_d1         <= a3_d0;
            a3_v1         <= a3_v0;
            act_in3       <= a3_d1;
            lane_valid[2] <= a3_v1;

            case (state)
                IDLE: begin
                    if (start) begin
                        w_out       <= w_in;
                        len_r       <= len;
                        acc_cnt     <= '0;
                        weight_load <= 1'b1;
                        clear       <= 1'b1;
                        busy        <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    drain_cnt <= '0;
                    state     <= (len_r != 8'd0) ? STREAM : DRAIN;
                end
                STREAM: begin
                    if (hs) begin
                        acc_cnt <= acc_cnt + 8'd1;
                        if (acc_cnt == len_r - 8'd1) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DCNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sa3x3_act_feeder.sv
// Randomized bench for sa3x3_act_feeder against a cycle-indexed job model.
module tb_sa3x3_act_feeder;

    localparam int unsigned DW  = 8;
    localparam int unsigned DC  = 5;
    localparam int unsigned CAP = 1024;
    localparam int unsigned WW  = 9 * DW;
    localparam int unsigned AW  = 3 * DW;

    logic          clk;
    logic          rst;
    logic          start;
    logic [7:0]    len;
    logic [WW-1:0] w_in;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_data;
    logic [WW-1:0] w_out;
    logic          weight_load;
    logic          clear;
    logic [DW-1:0] act_in1;
    logic [DW-1:0] act_in2;
    logic [DW-1:0] act_in3;
    logic [2:0]    lane_valid;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;

    logic          vpat [CAP];
    logic [AW-1:0] vdat [CAP];
    logic [WW-1:0] wts;

    sa3x3_act_feeder #(.DATA_W(DW), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .w_in(w_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .w_out(w_out), .weight_load(weight_load), .clear(clear),
        .act_in1(act_in1), .act_in2(act_in2), .act_in3(act_in3),
        .lane_valid(lane_valid), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_wout"},  72'(w_out), 72'(0));
        chk({pfx, "_wl"},    72'(weight_load), 72'(0));
        chk({pfx, "_clr"},   72'(clear), 72'(0));
        chk({pfx, "_acts"},  72'({act_in3, act_in2, act_in1}), 72'(0));
        chk({pfx, "_lv"},    72'(lane_valid), 72'(0));
        chk({pfx, "_rdy"},   72'(in_ready), 72'(0));
        chk({pfx, "_busy"},  72'(busy), 72'(0));
        chk({pfx, "_done"},  72'(done), 72'(0));
    endtask

    task automatic rand_w(output logic [WW-1:0] w);
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        w = r[WW-1:0];
    endtask

    task automatic fill_rand(input int pct);
        for (int c = 0; c < CAP; c++) begin
            vpat[c] = ($urandom_range(99) < pct);
            vdat[c] = AW'($urandom());
        end
    endtask

    // Cycle 0 = start sampled. Expected outputs derive from the handshake history:
    // lane k shows element k of the vector accepted k cycles earlier; done at last hs + DC + 1.
    task automatic run_job(input int len_i, input int start2_cyc, input int rst_cyc);
        int            acc;
        int            last;
        bit            known;
        bit            hs [CAP];
        logic [AW-1:0] hd [CAP];
        bit            e_rdy, e_busy, e_done;
        logic [DW-1:0] e1, e2, e3;
        logic [2:0]    e_lv;
        logic [WW-1:0] rw;
        acc   = 0;
        known = (len_i == 0);
        last  = 1;
        for (int c = 0; c < CAP; c++) begin
            @(negedge clk);
            hs[c] = 1'b0;
            if (rst_cyc >= 0 && c == rst_cyc + 1) begin
                chk_zero($sformatf("midrst_c%0d", c));
                rst      = 1'b0;
                start    = 1'b0;
                in_valid = 1'b0;
                return;
            end
            e_rdy  = (c >= 2) && (acc < len_i);
            e_busy = (c >= 1) && (!known || c <= last + int'(DC));
            e_done = known && (c == last + int'(DC) + 1);
            e1 = '0; e2 = '0; e3 = '0; e_lv = '0;
            if (c >= 1 && hs[c-1]) begin e1 = hd[c-1][DW-1:0];      e_lv[0] = 1'b1; end
            if (c >= 2 && hs[c-2]) begin e2 = hd[c-2][2*DW-1:DW];   e_lv[1] = 1'b1; end
            if (c >= 3 && hs[c-3]) begin e3 = hd[c-3][3*DW-1:2*DW]; e_lv[2] = 1'b1; end
            chk($sformatf("c%0d_rdy", c),  72'(in_ready), 72'(e_rdy));
            chk($sformatf("c%0d_busy", c), 72'(busy), 72'(e_busy));
            chk($sformatf("c%0d_done", c), 72'(done), 72'(e_done));
            chk($sformatf("c%0d_wl", c),   72'(weight_load), 72'(c == 1));
            chk($sformatf("c%0d_clr", c),  72'(clear), 72'(c == 1));
            chk($sformatf("c%0d_act1", c), 72'(act_in1), 72'(e1));
            chk($sformatf("c%0d_act2", c), 72'(act_in2), 72'(e2));
            chk($sformatf("c%0d_act3", c), 72'(act_in3), 72'(e3));
            chk($sformatf("c%0d_lv", c),   72'(lane_valid), 72'(e_lv));
            if (c >= 1) chk($sformatf("c%0d_wout", c), 72'(w_out), 72'(wts));
            if (known && c == last + int'(DC) + 2) begin
                start    = 1'b0;
                in_valid = 1'b0;
                return;
            end
            rand_w(rw);
            start    = (c == 0) || (c == start2_cyc);
            w_in     = (c == 0) ? wts : rw;
            len      = (c == 0) ? 8'(len_i) : 8'($urandom());
            in_valid = vpat[c];
            in_data  = vdat[c];
            if (c == rst_cyc) rst = 1'b1;
            if (vpat[c] && e_rdy) begin
                hs[c] = 1'b1;
                hd[c] = vdat[c];
                acc++;
                if (acc == len_i) begin
                    known = 1'b1;
                    last  = c;
                end
            end
        end
        chk("job_timeout", 72'(1), 72'(0));
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        len      = '0;
        w_in     = '0;
        in_valid = 1'b0;
        in_data  = '0;

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start    = 1'($urandom());
            in_valid = 1'($urandom());
            len      = 8'($urandom());
            in_data  = AW'($urandom());
            rand_w(w_in);
        end
        @(negedge clk);
        chk_zero("reset");
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;

        // Basic job: weights 1..9, three back-to-back vectors
        for (int i = 0; i < 9; i++) wts[i*DW +: DW] = DW'(i + 1);
        fill_rand(0);
        vpat[2] = 1'b1; vdat[2] = {8'd3, 8'd2, 8'd1};
        vpat[3] = 1'b1; vdat[3] = {8'd6, 8'd5, 8'd4};
        vpat[4] = 1'b1; vdat[4] = {8'd9, 8'd8, 8'd7};
        run_job(3, -1, -1);

        // Bubbles between two vectors
        rand_w(wts);
        fill_rand(0);
        vpat[2] = 1'b1;
        vpat[5] = 1'b1;
        run_job(2, -1, -1);

        // Empty job with valid toggling throughout
        rand_w(wts);
        fill_rand(60);
        run_job(0, -1, -1);

        // Second start mid-job is ignored
        rand_w(wts);
        fill_rand(70);
        run_job(4, 3, -1);

        // Mid-job reset, then a fresh job
        rand_w(wts);
        fill_rand(100);
        run_job(5, -1, 4);
        rand_w(wts);
        fill_rand(80);
        run_job(5, -1, -1);

        // Random jobs
        for (int j = 0; j < 12; j++) begin
            rand_w(wts);
            fill_rand(int'($urandom_range(30, 100)));
            run_job(int'($urandom_range(0, 20)), (j % 3 == 0) ? int'($urandom_range(2, 8)) : -1, -1);
        end

        // Maximum length
        rand_w(wts);
        fill_rand(90);
        run_job(255, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
